ula_mult_div: RTL

//  Parametrised next-generation ULA: the same single-cycle op set as the current ULA, plus an

---
 rtl/ula_mult_div_pkg.sv | 39 +++
 rtl/ula_mult_div_md_seq.sv | 116 +++++++++++
 rtl/ula_mult_div.sv | 88 ++++++++
 3 files changed

// File: rtl/ula_mult_div_pkg.sv
// Shared definitions for the ULA: 5-bit operation codes and the mult/div sequencer states.
package ula_mult_div_pkg;

  localparam logic [4:0] OP_ADD   = 5'h00;
  localparam logic [4:0] OP_SUB   = 5'h01;
  localparam logic [4:0] OP_AND   = 5'h02;
  localparam logic [4:0] OP_OR    = 5'h03;
  localparam logic [4:0] OP_SLT   = 5'h04;
  localparam logic [4:0] OP_XOR   = 5'h05;
  localparam logic [4:0] OP_NOR   = 5'h06;
  localparam logic [4:0] OP_SLL   = 5'h07;
  localparam logic [4:0] OP_SRL   = 5'h08;
  localparam logic [4:0] OP_SRA   = 5'h09;
  localparam logic [4:0] OP_SLTU  = 5'h0A;
  localparam logic [4:0] OP_JR    = 5'h0B;
  localparam logic [4:0] OP_BEQ   = 5'h0C;
  localparam logic [4:0] OP_JAL   = 5'h0D;
  localparam logic [4:0] OP_BNE   = 5'h0E;
  localparam logic [4:0] OP_LUI   = 5'h0F;
  localparam logic [4:0] OP_MULT  = 5'h10;
  localparam logic [4:0] OP_MULTU = 5'h11;
  localparam logic [4:0] OP_DIV   = 5'h12;
  localparam logic [4:0] OP_DIVU  = 5'h13;
  localparam logic [4:0] OP_MFHI  = 5'h14;
  localparam logic [4:0] OP_MFLO  = 5'h15;
  localparam logic [4:0] OP_MTHI  = 5'h16;
  localparam logic [4:0] OP_MTLO  = 5'h17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    AJUSTE = 2'd2
  } md_state_t;

  function automatic logic isMdOp(input logic [4:0] code);
    return (code >= OP_MULT) && (code <= OP_DIVU);
  endfunction

endpackage

// File: rtl/ula_mult_div_md_seq.sv
// Iterative multiply/divide sequencer: one shift-add or restoring-subtract step per clock
// on operand magnitudes, then a single fix-up cycle that presents the HI/LO write value.
module ula_md_seq
  import ula_mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ocupado_o,
  output logic             pronto_o,
  output logic             wr_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  md_state_t          state_q;
  logic [SHW-1:0]     cnt_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               ocupado_q, pronto_q;

  // op bit 1 selects divide, op bit 0 selects unsigned
  logic               startNeg, negA, negB, isDiv;
  logic [WIDTH-1:0]   startMagA, magB;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH+1:0]   divTrial;
  logic [WIDTH-1:0]   divRem;
  logic [2*WIDTH-1:0] accMul_d, accDiv_d, product;
  logic [WIDTH-1:0]   quot, rem;

  always_comb begin
    startNeg  = ~op_i[0] & a_i[WIDTH-1];
    startMagA = startNeg ? (~a_i + 1'b1) : a_i;
    isDiv     = op_q[1];
    negA      = ~op_q[0] & a_q[WIDTH-1];
    negB      = ~op_q[0] & b_q[WIDTH-1];
    magB      = negB ? (~b_q + 1'b1) : b_q;

    mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, magB} : {(WIDTH+1){1'b0}});
    accMul_d = {mulSum, acc_q[WIDTH-1:1]};

    // Two guard bits keep the trial subtraction's sign unambiguous for large unsigned divisors
    divTrial = {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {2'b00, magB};
    divRem   = divTrial[WIDTH+1] ? acc_q[2*WIDTH-2:WIDTH-1] : divTrial[WIDTH-1:0];
    accDiv_d = {divRem, acc_q[WIDTH-2:0], ~divTrial[WIDTH+1]};

    product = (negA ^ negB) ? (~acc_q + 1'b1) : acc_q;
    quot    = acc_q[WIDTH-1:0];
    rem     = acc_q[2*WIDTH-1:WIDTH];

    hi_o = product[2*WIDTH-1:WIDTH];
    lo_o = product[WIDTH-1:0];
    if (isDiv) begin
      if (b_q == '0) begin
        hi_o = a_q;
        lo_o = '1;
      end else begin
        hi_o = negA ? (~rem + 1'b1) : rem;
        lo_o = (negA ^ negB) ? (~quot + 1'b1) : quot;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            op_q      <= op_i;
            a_q       <= a_i;
            b_q       <= b_i;
            acc_q     <= {{WIDTH{1'b0}}, startMagA};
            cnt_q     <= '0;
            ocupado_q <= 1'b1;
            state_q   <= CALC;
          end
        end
        CALC: begin
          acc_q <= isDiv ? accDiv_d : accMul_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) state_q <= AJUSTE;
        end
        AJUSTE: begin
          ocupado_q <= 1'b0;
          pronto_q  <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ocupado_o = ocupado_q;
  assign pronto_o  = pronto_q;
  assign wr_o      = (state_q == AJUSTE);

endmodule

// File: rtl/ula_mult_div.sv
// EX-stage ULA: single-cycle combinational operations plus the HI/LO registers that are
// loaded by the iterative multiply/divide sequencer or by mthi/mtlo.
module ula_mult_div
  import ula_mult_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       codigo_controle,
  input  logic [WIDTH-1:0] operando_A,
  input  logic [WIDTH-1:0] operando_B,
  input  logic             iniciar,
  output logic [WIDTH-1:0] resultado,
  output logic             zero_flag,
  output logic             ocupado,
  output logic             pronto,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] mdHi, mdLo;
  logic             mdWr, mdStart;
  logic [SHW-1:0]   shamt;

  assign shamt   = operando_B[SHW-1:0];
  assign mdStart = iniciar & isMdOp(codigo_controle);

  ula_md_seq #(.WIDTH(WIDTH)) u_md_seq (
    .clock     (clock),
    .reset     (reset),
    .start_i   (mdStart),
    .op_i      (codigo_controle[1:0]),
    .a_i       (operando_A),
    .b_i       (operando_B),
    .ocupado_o (ocupado),
    .pronto_o  (pronto),
    .wr_o      (mdWr),
    .hi_o      (mdHi),
    .lo_o      (mdLo)
  );

  always_comb begin
    resultado = '0;
    zero_flag = 1'b0;
    case (codigo_controle)
      OP_ADD:  resultado = operando_A + operando_B;
      OP_SUB:  resultado = operando_A - operando_B;
      OP_AND:  resultado = operando_A & operando_B;
      OP_OR:   resultado = operando_A | operando_B;
      OP_SLT:  resultado = {{(WIDTH-1){1'b0}}, $signed(operando_A) < $signed(operando_B)};
      OP_XOR:  resultado = operando_A ^ operando_B;
      OP_NOR:  resultado = ~(operando_A | operando_B);
      OP_SLL:  resultado = operando_A << shamt;
      OP_SRL:  resultado = operando_A >> shamt;
      OP_SRA:  resultado = $unsigned($signed(operando_A) >>> shamt);
      OP_SLTU: resultado = {{(WIDTH-1){1'b0}}, operando_A < operando_B};
      OP_JR:   zero_flag = 1'b1;
      OP_BEQ:  zero_flag = (operando_A == operando_B);
      OP_JAL:  zero_flag = 1'b1;
      OP_BNE:  zero_flag = (operando_A != operando_B);
      OP_LUI:  resultado = {operando_A[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_MFHI: resultado = hi_q;
      OP_MFLO: resultado = lo_q;
      default: ;
    endcase
  end

  // Sequencer results take priority; mthi/mtlo only land while no operation is in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (mdWr) begin
      hi_q <= mdHi;
      lo_q <= mdLo;
    end else if (!ocupado) begin
      if (codigo_controle == OP_MTHI) hi_q <= operando_A;
      if (codigo_controle == OP_MTLO) lo_q <= operando_A;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
